edge_generator: RTL and testbench
=================================

Name: edge_generator

Overview:
- Programmable square-wave stimulus source with a registered, glitch-free output; the transmit side of the rising-edge detection path.
- Produces a known number of rising edges at a known period for the frequency counter's input.
- Used in self-test and in benches to drive the edge detector and counter with exact, repeatable edge trains.

Parameters:
- CNT_W, 16, width of the half-period, edge-number and edge-count fields.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a run; sampled only in IDLE.
- stop  input  1  abort request; honoured in any state.
- half_period  input  CNT_W  clocks per high phase and per low phase; latched at start.
- num_edges  input  CNT_W  rising edges to produce; latched at start; 0 = free-run until stop.
- signal  output  1  generated square wave, registered.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a counted run completes.
- edge_count  output  CNT_W  rising edges produced in the current or last run.

Behaviour:
- Reset (async, active-high): state=IDLE; signal=0, busy=0, done=0, edge_count=0; latched fields and phase timer cleared.
- States: IDLE, HIGH, LOW.
- IDLE:
  - start=1 and stop=0 at edge E: latch half_period (0 is treated as 1) and num_edges; go to HIGH.
  - After E: signal=1, busy=1, edge_count=1. Each new run clears edge_count to 1.
  - start=1 together with stop=1 in IDLE: no run; stays IDLE.
- HIGH:
  - signal stays 1 for exactly H clocks (H = latched half-period), then LOW.
- LOW:
  - signal stays 0 for H clocks.
  - At the end of the phase, if num_edges=0 or edge_count<num_edges: go to HIGH and increment edge_count on the same edge signal rises.
  - Otherwise: go to IDLE, busy=0, done=1 for one cycle.
- Timing:
  - Period = 2H clocks; duty 50%.
  - Counted run with start at edge 0: busy high for cycles 1..2HN; done high in cycle 2HN+1 only.
- edge_count:
  - Holds its value in IDLE until the next start.
  - In free-run it wraps modulo 2^CNT_W.
  - In a counted run it never exceeds num_edges.
- stop (HIGH or LOW): on the next edge signal=0, busy=0, state=IDLE. done is not asserted; edge_count holds.
- start while busy: ignored; latched fields are unchanged.
- half_period and num_edges may change during a run with no effect.
- done and start in the same cycle: start is accepted (state is already IDLE).
- Reset mid-run: immediate return to reset values; no done.
- signal is driven directly from a flop: no combinational path to the output.

Test Plan:
- Reset, then start with H=3, N=2 -> signal high cycles 1-3, low 4-6, high 7-9, low 10-12; done only in cycle 13; edge_count 1 then 2; busy cycles 1-12.
- H=1, N=4, signal fed through the edge detector -> 4 detect pulses, period 2 clocks; done at cycle 9; edge_count=4.
- H=0, N=1 -> identical to H=1: high 1 clock, low 1 clock, done in cycle 3.
- N=0, H=2, run 40 clocks, then stop -> 10 rising edges; signal=0 and busy=0 the cycle after stop; no done; edge_count=10 held.
- Mid-run start with different H/N, then start+stop together in IDLE -> mid-run start has no effect on waveform; start+stop produces no run.
- Async reset asserted between clock edges during HIGH -> signal, busy, done, edge_count=0 immediately; next start runs normally from edge_count=1.

Source files
------------

// File: rtl/edge_generator.sv
// Programmable square-wave edge source: emits a counted (or free-running) train of
// rising edges with a period of 2*half_period clocks and a registered output.
//
// state  | meaning
// S_IDLE | waiting for start; signal low, edge_count holds the last run's total
// S_HIGH | high phase of the current period, phase timer counting down
// S_LOW  | low phase; at terminal count either rise again or finish the run
module edge_generator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] num_edges,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_half, w_half;
  logic [CNT_W-1:0] r_num, w_num;
  logic [CNT_W-1:0] r_timer, w_timer;
  logic [CNT_W-1:0] r_edge_count, w_edge_count;
  logic             r_signal, w_signal;
  logic             r_busy, w_busy;
  logic             r_done, w_done;

  logic [CNT_W-1:0] w_half_in;
  logic             w_timer_tc;
  logic             w_more_edges;

  // A zero half-period would stall the timer, so it runs as one clock per phase.
  assign w_half_in    = (half_period == '0) ? CNT_W'(1) : half_period;
  assign w_timer_tc   = (r_timer == '0);
  assign w_more_edges = (r_num == '0) || (r_edge_count < r_num);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_half       <= '0;
      r_num        <= '0;
      r_timer      <= '0;
      r_edge_count <= '0;
      r_signal     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_half       <= w_half;
      r_num        <= w_num;
      r_timer      <= w_timer;
      r_edge_count <= w_edge_count;
      r_signal     <= w_signal;
      r_busy       <= w_busy;
      r_done       <= w_done;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_half       = r_half;
    w_num        = r_num;
    w_timer      = r_timer;
    w_edge_count = r_edge_count;
    w_signal     = r_signal;
    w_busy       = r_busy;
    w_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_half       = w_half_in;
          w_num        = num_edges;
          w_timer      = w_half_in - CNT_W'(1);
          w_edge_count = CNT_W'(1);
          w_signal     = 1'b1;
          w_busy       = 1'b1;
          w_state      = S_HIGH;
        end
      end
      S_HIGH: begin
        if (stop) begin
          w_signal = 1'b0;
          w_busy   = 1'b0;
          w_state  = S_IDLE;
        end else if (w_timer_tc) begin
          w_timer  = r_half - CNT_W'(1);
          w_signal = 1'b0;
          w_state  = S_LOW;
        end else begin
          w_timer = r_timer - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (stop) begin
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else if (w_timer_tc) begin
          if (w_more_edges) begin
            w_timer      = r_half - CNT_W'(1);
            w_edge_count = r_edge_count + CNT_W'(1);
            w_signal     = 1'b1;
            w_state      = S_HIGH;
          end else begin
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_IDLE;
          end
        end else begin
          w_timer = r_timer - CNT_W'(1);
        end
      end
      default: begin
        w_signal = 1'b0;
        w_busy   = 1'b0;
        w_state  = S_IDLE;
      end
    endcase
  end

  assign signal     = r_signal;
  assign busy       = r_busy;
  assign done       = r_done;
  assign edge_count = r_edge_count;

endmodule

// File: tb/tb_edge_generator.sv
// Bench for edge_generator: a waveform model computed from the run's elapsed
// cycle index (period/phase arithmetic) is compared against the DUT every cycle.
module tb_edge_generator;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] half_period;
  logic [CNT_W-1:0] num_edges;
  logic             signal;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] edge_count;

  int n_checks = 0;
  int n_fail   = 0;

  bit               m_active;
  longint           m_idx, m_h, m_n;
  logic             m_sig, m_busy, m_done;
  logic [CNT_W-1:0] m_ec;

  edge_generator #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .half_period(half_period), .num_edges(num_edges),
    .signal(signal), .busy(busy), .done(done), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0; m_idx = 0; m_h = 1; m_n = 0;
    m_sig = 0; m_busy = 0; m_done = 0; m_ec = '0;
  endtask

  // One clock: advance the model using the inputs applied for this edge, then
  // return at the following falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    m_done = 1'b0;
    if (reset) begin
      model_reset();
    end else if (m_active) begin
      if (stop) begin
        m_active = 0; m_sig = 0; m_busy = 0;
      end else begin
        m_idx++;
        if (m_n != 0 && m_idx == 2 * m_h * m_n) begin
          m_active = 0; m_sig = 0; m_busy = 0; m_done = 1;
        end else begin
          m_sig = (m_idx % (2 * m_h)) < m_h;
          m_ec  = CNT_W'(m_idx / (2 * m_h) + 1);
        end
      end
    end else if (start && !stop) begin
      m_active = 1; m_idx = 0;
      m_h = (half_period == 0) ? 1 : longint'(half_period);
      m_n = longint'(num_edges);
      m_sig = 1; m_busy = 1; m_ec = CNT_W'(1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; start = 0; stop = 0; half_period = '0; num_edges = '0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({signal, busy, done, edge_count} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_state got %h exp 0", {signal, busy, done, edge_count});
    end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({signal, busy, done, edge_count} !== {m_sig, m_busy, m_done, m_ec}) begin
        n_fail++;
        $display("FAIL reset_idle got %h exp %h", {signal, busy, done, edge_count}, {m_sig, m_busy, m_done, m_ec});
      end
    end
  endtask

  task automatic test_basic();
    int done_cyc;
    done_cyc = -1;
    half_period = 3; num_edges = 2; start = 1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = 0;
      if (done) done_cyc = c;
      n_checks++;
      if ({signal, busy, done, edge_count} !== {m_sig, m_busy, m_done, m_ec}) begin
        n_fail++;
        $display("FAIL basic cyc %0d got %h exp %h", c, {signal, busy, done, edge_count}, {m_sig, m_busy, m_done, m_ec});
      end
    end
    n_checks++;
    if (done_cyc != 13) begin
      n_fail++;
      $display("FAIL basic_done_cycle got %0d exp 13", done_cyc);
    end
  endtask

  task automatic test_h1_detector();
    int done_cyc, n_det, last_det, prev_sig;
    bit gap_ok;
    done_cyc = -1; n_det = 0; last_det = -1; prev_sig = 0; gap_ok = 1;
    half_period = 1; num_edges = 4; start = 1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 0;
      if (signal && !prev_sig) begin
        if (last_det >= 0 && c - last_det != 2) gap_ok = 0;
        last_det = c;
        n_det++;
      end
      prev_sig = int'(signal);
      if (done) done_cyc = c;
      n_checks++;
      if ({signal, busy, done, edge_count} !== {m_sig, m_busy, m_done, m_ec}) begin
        n_fail++;
        $display("FAIL h1 cyc %0d got %h exp %h", c, {signal, busy, done, edge_count}, {m_sig, m_busy, m_done, m_ec});
      end
    end
    n_checks++;
    if (n_det != 4 || !gap_ok || done_cyc != 9 || edge_count !== 16'd4) begin
      n_fail++;
      $display("FAIL h1_detect got det=%0d gap_ok=%0d done=%0d ec=%0d exp det=4 gap_ok=1 done=9 ec=4", n_det, gap_ok, done_cyc, edge_count);
    end
  endtask

  task automatic test_h0();
    int done_cyc;
    done_cyc = -1;
    half_period = 0; num_edges = 1; start = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 0;
      if (done) done_cyc = c;
      n_checks++;
      if ({signal, busy, done, edge_count} !== {m_sig, m_busy, m_done, m_ec}) begin
        n_fail++;
        $display("FAIL h0 cyc %0d got %h exp %h", c, {signal, busy, done, edge_count}, {m_sig, m_busy, m_done, m_ec});
      end
    end
    n_checks++;
    if (done_cyc != 3) begin
      n_fail++;
      $display("FAIL h0_done_cycle got %0d exp 3", done_cyc);
    end
  endtask

  task automatic test_free_run();
    bit saw_done;
    saw_done = 0;
    half_period = 2; num_edges = 0; start = 1;
    for (int c = 1; c <= 44; c++) begin
      if (c == 41) stop = 1;
      tick();
      start = 0; stop = 0;
      if (done) saw_done = 1;
      n_checks++;
      if ({signal, busy, done, edge_count} !== {m_sig, m_busy, m_done, m_ec}) begin
        n_fail++;
        $display("FAIL free_run cyc %0d got %h exp %h", c, {signal, busy, done, edge_count}, {m_sig, m_busy, m_done, m_ec});
      end
    end
    n_checks++;
    if (saw_done || edge_count !== 16'd10 || signal !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL free_run_stop got done_seen=%0d ec=%0d sig=%b busy=%b exp 0 10 0 0", saw_done, edge_count, signal, busy);
    end
  endtask

  task automatic test_back_to_back();
    half_period = 2; num_edges = 3;
    for (int c = 0; c < 24; c++) begin
      start = (c == 0 || c == 3 || c == 13 || c == 17);
      stop  = (c == 17);
      if (c == 3)  begin half_period = 5; num_edges = 1; end
      if (c == 13) begin half_period = 1; num_edges = 1; end
      tick();
      start = 0; stop = 0;
      n_checks++;
      if ({signal, busy, done, edge_count} !== {m_sig, m_busy, m_done, m_ec}) begin
        n_fail++;
        $display("FAIL back_to_back edge %0d got %h exp %h", c, {signal, busy, done, edge_count}, {m_sig, m_busy, m_done, m_ec});
      end
    end
  endtask

  task automatic test_async_reset();
    half_period = 3; num_edges = 2; start = 1;
    tick();
    start = 0;
    tick();
    #2 reset = 1;
    model_reset();
    #1;
    n_checks++;
    if ({signal, busy, done, edge_count} !== 19'h0) begin
      n_fail++;
      $display("FAIL async_reset got %h exp 0", {signal, busy, done, edge_count});
    end
    tick();
    reset = 0;
    half_period = 1; num_edges = 2; start = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 0;
      n_checks++;
      if ({signal, busy, done, edge_count} !== {m_sig, m_busy, m_done, m_ec}) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d got %h exp %h", c, {signal, busy, done, edge_count}, {m_sig, m_busy, m_done, m_ec});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      start       = ($urandom_range(0, 5) == 0);
      stop        = ($urandom_range(0, 24) == 0);
      half_period = CNT_W'($urandom_range(0, 3));
      num_edges   = CNT_W'($urandom_range(0, 4));
      tick();
      start = 0; stop = 0;
      n_checks++;
      if ({signal, busy, done, edge_count} !== {m_sig, m_busy, m_done, m_ec}) begin
        n_fail++;
        $display("FAIL random edge %0d got %h exp %h", c, {signal, busy, done, edge_count}, {m_sig, m_busy, m_done, m_ec});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_h1_detector();
    test_h0();
    test_free_run();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
